// File: rtl/mips_mem_pkg.sv
// Shared types, constants and address helpers for the MIPS data-memory responder.
package mips_mem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WORD_BYTES  = 4;
    // Byte distance of the memory-mapped output word below the top of the array.
    localparam int MMIO_OFFSET = WORD_BYTES;

    // True when the byte address falls inside an array of 2**aw words.
    function automatic logic addr_in_range(input logic [31:0] a, input int unsigned aw);
        return (a >> (aw + 2)) == 32'd0;
    endfunction

    // True when the byte address is word aligned.
    function automatic logic addr_aligned(input logic [31:0] a);
        return a[1:0] == 2'b00;
    endfunction

    // A core store only commits when it is both aligned and in range.
    function automatic logic addr_legal(input logic [31:0] a, input int unsigned aw);
        return addr_aligned(a) && addr_in_range(a, aw);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: one synchronous write port, one combinational read port.
// Contents are deliberately never reset so a boot image survives a core reset.
module dmem_array #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Single write port, committed on the rising edge.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read is asynchronous so a same-cycle write is seen only from the next cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined MIPS core M stage.
// Boot-loads an image through a valid/ready port while holding the core in reset,
// then serves combinational loads, clocked stores and sticky error flags.
// Optional feature macro: DMEM_MMIO_EN (top word becomes an output register).
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    output logic [31:0]       rdata,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              core_hold,
    output logic              err_misalign,
    output logic              err_oor
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0]       mmio_data,
    output logic              mmio_strobe
`endif
);

    state_t            state, state_next;
    logic              in_load, in_run, ld_fire;
    logic              core_range, core_align, core_wr, mem_wr;
    logic [ADDR_W-1:0] idx;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [31:0]       arr_wdata, arr_rdata;

    assign idx        = addr[ADDR_W+1:2];
    assign core_range = addr_in_range(addr, ADDR_W);
    assign core_align = addr_aligned(addr);
    assign in_load    = (state == LOAD);
    // Reset wins over everything, so RUN activity is masked while it is asserted.
    assign in_run     = (state == RUN) && !reset;
    assign ld_fire    = in_load && ld_valid && !reset;
    assign core_wr    = in_run && we && addr_legal(addr, ADDR_W);

`ifdef DMEM_MMIO_EN
    localparam logic [ADDR_W-1:0] MMIO_IDX =
        ADDR_W'((DEPTH * WORD_BYTES - MMIO_OFFSET) / WORD_BYTES);

    logic top_hit, mmio_wr;
    assign top_hit = core_range && (idx == MMIO_IDX);
    assign mmio_wr = core_wr && top_hit;
    assign mem_wr  = core_wr && !mmio_wr;

    // Output register and one-cycle strobe for stores to the top word.
    always_ff @(posedge clk) begin
        if (reset) begin
            mmio_data   <= '0;
            mmio_strobe <= 1'b0;
        end else begin
            mmio_strobe <= mmio_wr;
            if (mmio_wr) mmio_data <= wdata;
        end
    end
`else
    assign mem_wr = core_wr;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    // Next state and handshake/hold outputs.
    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        core_hold  = 1'b0;
        case (state)
            LOAD: begin
                ld_ready  = 1'b1;
                core_hold = 1'b1;
                if (ld_valid && ld_last) state_next = RUN;
            end
            RUN: ;
            default: state_next = LOAD;
        endcase
        // Hold the core the moment reset is seen, not one edge later.
        if (reset) core_hold = 1'b1;
    end

    // Array write port: loader in LOAD, legal core stores in RUN.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = idx;
        arr_wdata = wdata;
        if (ld_fire) begin
            arr_we    = 1'b1;
            arr_waddr = ld_addr;
            arr_wdata = ld_data;
        end else if (mem_wr) begin
            arr_we = 1'b1;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .waddr(arr_waddr),
        .wdata(arr_wdata),
        .raddr(idx),
        .rdata(arr_rdata)
    );

    // Load data: zero outside RUN or out of range; misaligned reads use the floor word.
    always_comb begin
        rdata = '0;
        if (in_run && core_range) begin
            rdata = arr_rdata;
`ifdef DMEM_MMIO_EN
            if (top_hit) rdata = mmio_data;
`endif
        end
    end

    // Sticky error flags; only stores count, since addr carries ALU results every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_misalign <= 1'b0;
            err_oor      <= 1'b0;
        end else if (in_run && we) begin
            if (!core_align) err_misalign <= 1'b1;
            if (!core_range) err_oor      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: boot load with gaps, table-driven RUN
// accesses through a scoreboard queue, and hand-written reset/MMIO sequences.
module tb_dmem_responder;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       addr, wdata, rdata;
    logic              we;
    logic              ld_valid, ld_ready, ld_last;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              core_hold, err_misalign, err_oor;
`ifdef DMEM_MMIO_EN
    logic [31:0]       mmio_data;
    logic              mmio_strobe;
`endif

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .wdata       (wdata),
        .we          (we),
        .rdata       (rdata),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .core_hold   (core_hold),
        .err_misalign(err_misalign),
        .err_oor     (err_oor)
`ifdef DMEM_MMIO_EN
        ,
        .mmio_data   (mmio_data),
        .mmio_strobe (mmio_strobe)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic        exp_oor;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic last);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
        #1;
        check("hold_during_load", {31'b0, core_hold}, 32'd1);
        check("ready_during_load", {31'b0, ld_ready}, 32'd1);
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic add_vec(input string n, input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [31:0] er, input logic em, input logic eo);
        vec_t v;
        v.name = n; v.addr = a; v.we = w; v.wdata = d;
        v.exp_rdata = er; v.exp_mis = em; v.exp_oor = eo;
        vecs.push_back(v);
    endtask

    task automatic core_read(input string n, input logic [31:0] a, input logic [31:0] exp);
        sb_t s;
        addr = a; we = 1'b0;
        s.name = n; s.exp = exp;
        sb.push_back(s);
        #1;
        s = sb.pop_front();
        check(s.name, rdata, s.exp);
    endtask

    initial begin
        sb_t s;
        logic [31:0] top_exp;
`ifdef DMEM_MMIO_EN
        top_exp = 32'h0;
`else
        top_exp = 32'h3FF3FF00;
`endif
        // RUN-phase vectors: flags are the values seen before that vector's edge.
        add_vec("rd_idx2",       32'h08,   0, 0,            32'h33333333, 0, 0);
        add_vec("rd_idx0",       32'h00,   0, 0,            32'h11111111, 0, 0);
        add_vec("rd_idx1",       32'h04,   0, 0,            32'h22222222, 0, 0);
        add_vec("rd_gap_idx7",   32'h1C,   0, 0,            32'h77777777, 0, 0);
        add_vec("st_old_0x40",   32'h40,   1, 32'hDEADBEEF, 32'h16161616, 0, 0);
        add_vec("rd_new_0x40",   32'h40,   0, 0,            32'hDEADBEEF, 0, 0);
        add_vec("rd_oor_1004",   32'h1004, 0, 0,            32'h0,        0, 0);
        add_vec("rd_mis_0x43",   32'h43,   0, 0,            32'hDEADBEEF, 0, 0);
        add_vec("rd_top",        32'hFFC,  0, 0,            top_exp,      0, 0);
        add_vec("st_mis_0x42",   32'h42,   1, 32'h0BADBAD0, 32'hDEADBEEF, 0, 0);
        add_vec("rd_after_mis",  32'h40,   0, 0,            32'hDEADBEEF, 1, 0);
        add_vec("st_oor_1000",   32'h1000, 1, 32'h0BADBAD1, 32'h0,        1, 0);
        add_vec("rd_oor_1000",   32'h1000, 0, 0,            32'h0,        1, 1);
        add_vec("rd_idx0_again", 32'h00,   0, 0,            32'h11111111, 1, 1);

        reset = 1'b1; addr = 32'h0; wdata = 32'h0; we = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = 32'h0; ld_last = 1'b0;
        tick();
        tick();
        check("rst_core_hold", {31'b0, core_hold}, 32'd1);
        check("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
        check("rst_err_mis", {31'b0, err_misalign}, 32'd0);
        check("rst_err_oor", {31'b0, err_oor}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        reset = 1'b0;

        // Boot load, including a three-cycle gap presenting junk with valid low.
        load_word(10'd0,    32'h11111111, 1'b0);
        load_word(10'd7,    32'h77777777, 1'b0);
        load_word(10'd16,   32'h16161616, 1'b0);
        load_word(10'd1023, 32'h3FF3FF00, 1'b0);
        ld_addr = 10'd7; ld_data = 32'h0BAD0BAD;
        for (int i = 0; i < 3; i++) begin
            addr = 32'h1C; we = 1'b1;
            #1;
            check("gap_rdata_zero", rdata, 32'h0);
            tick();
        end
        addr = 32'h0; we = 1'b0;
        load_word(10'd1, 32'h22222222, 1'b0);
        load_word(10'd2, 32'h33333333, 1'b1);
        #1;
        check("hold_low_after_last", {31'b0, core_hold}, 32'd0);
        check("ready_low_in_run", {31'b0, ld_ready}, 32'd0);
        check("no_flags_from_load", {30'b0, err_misalign, err_oor}, 32'd0);

        // Loader stays active in RUN with junk; it must be ignored.
        ld_valid = 1'b1; ld_addr = 10'd0; ld_data = 32'hBAD0BAD0; ld_last = 1'b1;
        foreach (vecs[i]) begin
            addr = vecs[i].addr; we = vecs[i].we; wdata = vecs[i].wdata;
            s.name = vecs[i].name; s.exp = vecs[i].exp_rdata;
            sb.push_back(s);
            #1;
            s = sb.pop_front();
            check(s.name, rdata, s.exp);
            check({s.name, "_mis"}, {31'b0, err_misalign}, {31'b0, vecs[i].exp_mis});
            check({s.name, "_oor"}, {31'b0, err_oor}, {31'b0, vecs[i].exp_oor});
            tick();
        end
        we = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;

`ifdef DMEM_MMIO_EN
        addr = 32'hFFC; we = 1'b1; wdata = 32'h000000A5;
        #1;
        check("mmio_strobe_pre", {31'b0, mmio_strobe}, 32'd0);
        tick();
        we = 1'b0; addr = 32'h0;
        #1;
        check("mmio_strobe_hi", {31'b0, mmio_strobe}, 32'd1);
        check("mmio_data", mmio_data, 32'hA5);
        tick();
        check("mmio_strobe_lo", {31'b0, mmio_strobe}, 32'd0);
        core_read("mmio_readback", 32'hFFC, 32'hA5);
`endif

        // Reset mid-run: hold rises while reset is sampled, flags clear, image kept.
        addr = 32'h0;
        reset = 1'b1;
        #1;
        check("midrst_hold_same_cycle", {31'b0, core_hold}, 32'd1);
        tick();
        reset = 1'b0;
        #1;
        check("midrst_hold", {31'b0, core_hold}, 32'd1);
        check("midrst_ready", {31'b0, ld_ready}, 32'd1);
        check("midrst_flags", {30'b0, err_misalign, err_oor}, 32'd0);
        check("midrst_rdata", rdata, 32'h0);
        load_word(10'd5, 32'h55555555, 1'b1);
        #1;
        check("reload_hold_low", {31'b0, core_hold}, 32'd0);
        core_read("retained_idx0", 32'h00, 32'h11111111);
        core_read("reload_idx5", 32'h14, 32'h55555555);
        core_read("retained_0x40", 32'h40, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
